inbound_mc_ctrl: RTL and testbench

INBOUND_MC_CTRL -- requirements
Module: inbound_mc_ctrl

---
 rtl/inbound_mc_ctrl_pkg.sv | 21 ++
 rtl/inbound_mc_ctrl_rr_arb.sv | 42 ++++
 rtl/inbound_mc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_inbound_mc_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inbound_mc_ctrl_pkg.sv
// Inbound multi-channel controller: shared types and constants.
// Command codes, register indices and the bus byte-swap helper.
package inbound_mc_ctrl_pkg;

  localparam logic [1:0] US_CMD_INVALID_TYPE = 2'd0;
  localparam logic [1:0] US_CMD_WR32_TYPE    = 2'd1;
  localparam logic [1:0] US_CMD_CPL_TYPE     = 2'd2;
  localparam logic [1:0] US_CMD_CPLD_TYPE    = 2'd3;

  localparam logic [4:0] REG_CMD    = 5'd0;
  localparam logic [4:0] REG_LEN    = 5'd1;
  localparam logic [4:0] REG_BUSY   = 5'd2;
  localparam logic [4:0] REG_DONE   = 5'd3;
  localparam logic [4:0] REG_IRQ_EN = 5'd4;
  localparam logic [4:0] REG_ADDR0  = 5'd8;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/inbound_mc_ctrl_rr_arb.sv
// Round-robin arbiter for the channel issue path.
// Search starts at the channel after the last grant; channel 0 after reset.
module rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [2:0]   grant_id
);

  logic [2:0]   start;
  logic [N-1:0] mask;
  logic [N-1:0] pick;

  // Prefer requests at or above start, wrap to the lowest otherwise
  always_comb begin
    for (int j = 0; j < N; j++) mask[j] = (3'(j) >= start);
    pick = ((req & mask) != '0) ? (req & mask) : req;
    grant = '0;
    grant_id = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (pick[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        grant_id = 3'(j);
      end
    end
  end

  // Move the search start past the channel just granted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start <= '0;
    end else if (advance) begin
      start <= (grant_id == 3'(N - 1)) ? 3'd0 : grant_id + 3'd1;
    end
  end

endmodule

// File: rtl/inbound_mc_ctrl.sv
// Inbound multi-channel DMA command controller.
// Register file, completion capture and upstream command issue.
module inbound_mc_ctrl
  import inbound_mc_ctrl_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int LEN_RST = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_wr_cmd_compl_i,
  input  logic [2:0]   cmd_id_i,
  input  logic         req_compl_i,
  input  logic         req_compl_with_data_i,
  output logic         to_rxe_compl_done_o,
  input  logic [10:0]  rd_addr_i,
  input  logic [3:0]   rd_be_i,
  output logic [31:0]  rd_data_o,
  input  logic [10:0]  wr_addr_i,
  input  logic [7:0]   wr_be_i,
  input  logic [31:0]  wr_data_i,
  input  logic         wr_en_i,
  output logic         wr_busy_o,
  input  logic [2:0]   req_tc_i,
  input  logic         req_td_i,
  input  logic         req_ep_i,
  input  logic [1:0]   req_attr_i,
  input  logic [9:0]   req_len_i,
  input  logic [15:0]  req_rid_i,
  input  logic [7:0]   req_tag_i,
  input  logic [7:0]   req_be_i,
  input  logic [12:0]  req_addr_i,
  input  logic         us_cmd_fifo_full_i,
  input  logic         us_cmd_fifo_prog_full_i,
  output logic [127:0] us_cmd_fifo_din_o,
  output logic         us_cmd_fifo_wr_en_o,
  output logic         irq_o
);

  logic [NUM_CH-1:0] pending, busy, done, irq_en;
  logic [NUM_CH-1:0] grant, issued, compl_hit;
  logic [NUM_CH-1:0] cmd_set, done_clr;
  logic [4:0]        len;
  logic [31:0]       addr [NUM_CH];
  logic [31:0]       addr_sel, wdata, rd_val;
  logic [54:0]       desc;
  logic              cpl_pend, cpld;
  logic              issue_cpl, issue_wr, wr_ok;
  logic [2:0]        grant_id;
  logic [4:0]        widx, ridx;
  logic              unused;

  assign unused = ^{rd_be_i, wr_be_i, us_cmd_fifo_prog_full_i,
                    rd_addr_i[10:5], wr_addr_i[10:5], req_addr_i[12:6]};

  assign wdata = bswap32(wr_data_i);
  assign widx  = wr_addr_i[4:0];
  assign ridx  = rd_addr_i[4:0];
  assign wr_ok = wr_en_i && !cpl_pend;

  assign issue_cpl = cpl_pend && !us_cmd_fifo_full_i;
  assign issue_wr  = !cpl_pend && (pending != '0) && !us_cmd_fifo_full_i;
  assign issued    = issue_wr ? grant : '0;

  assign cmd_set  = (wr_ok && widx == REG_CMD) ?
                    (wdata[NUM_CH-1:0] & ~busy & ~pending) : '0;
  assign done_clr = (wr_ok && widx == REG_DONE) ? wdata[NUM_CH-1:0] : '0;

  assign us_cmd_fifo_wr_en_o = issue_cpl || issue_wr;
  assign to_rxe_compl_done_o = issue_cpl;
  assign wr_busy_o           = cpl_pend;
  assign irq_o               = |(done & irq_en);

  rr_arb #(.N(NUM_CH)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (pending),
    .advance  (issue_wr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Completion hits and the granted channel's address
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      compl_hit[i] = up_wr_cmd_compl_i && cmd_id_i == 3'(i) && busy[i];
      if (grant[i]) addr_sel = addr[i];
    end
  end

  // Upstream command word, zero whenever nothing is issued
  always_comb begin
    us_cmd_fifo_din_o = '0;
    unique case (1'b1)
      issue_cpl: begin
        us_cmd_fifo_din_o[54:0]  = desc;
        us_cmd_fifo_din_o[56:55] = cpld ? US_CMD_CPLD_TYPE : US_CMD_CPL_TYPE;
        us_cmd_fifo_din_o[61:57] = len;
      end
      issue_wr: begin
        us_cmd_fifo_din_o[31:0]  = addr_sel;
        us_cmd_fifo_din_o[56:55] = US_CMD_WR32_TYPE;
        us_cmd_fifo_din_o[61:57] = len;
        us_cmd_fifo_din_o[64:62] = grant_id;
      end
      default: ;
    endcase
  end

  // Register read mux, little-endian internally
  always_comb begin
    rd_val = '0;
    case (ridx)
      REG_CMD:    rd_val = 32'(pending);
      REG_LEN:    rd_val = 32'(len);
      REG_BUSY:   rd_val = 32'(busy);
      REG_DONE:   rd_val = 32'(done);
      REG_IRQ_EN: rd_val = 32'(irq_en);
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (ridx == REG_ADDR0 + 5'(i)) rd_val = addr[i];
      end
    endcase
  end

  assign rd_data_o = bswap32(rd_val);

  // Channel state, registers and completion descriptor
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      busy     <= '0;
      done     <= '0;
      irq_en   <= '0;
      len      <= 5'(LEN_RST);
      cpl_pend <= 1'b0;
      cpld     <= 1'b0;
      desc     <= '0;
      for (int i = 0; i < NUM_CH; i++) addr[i] <= '0;
    end else begin
      pending <= (pending & ~issued) | cmd_set;
      busy    <= (busy | issued) & ~compl_hit;
      done    <= (done & ~done_clr) | compl_hit;
      if (wr_ok && widx == REG_LEN) len <= wdata[4:0];
      if (wr_ok && widx == REG_IRQ_EN) irq_en <= wdata[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++)
        if (wr_ok && widx == REG_ADDR0 + 5'(i)) addr[i] <= wdata;
      if (issue_cpl) begin
        cpl_pend <= 1'b0;
      end else if (!cpl_pend && req_compl_i) begin
        cpl_pend <= 1'b1;
        cpld     <= req_compl_with_data_i;
        desc     <= {req_tc_i, req_td_i, req_ep_i, req_attr_i, req_len_i,
                     req_rid_i, req_tag_i, req_be_i, req_addr_i[5:0]};
      end
    end
  end

endmodule

// File: tb/tb_inbound_mc_ctrl.sv
// Bench for inbound_mc_ctrl: register table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_inbound_mc_ctrl;
  import inbound_mc_ctrl_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         up_wr_cmd_compl_i = 1'b0;
  logic [2:0]   cmd_id_i = '0;
  logic         req_compl_i = 1'b0;
  logic         req_compl_with_data_i = 1'b0;
  logic         to_rxe_compl_done_o;
  logic [10:0]  rd_addr_i = '0;
  logic [3:0]   rd_be_i = '0;
  logic [31:0]  rd_data_o;
  logic [10:0]  wr_addr_i = '0;
  logic [7:0]   wr_be_i = '0;
  logic [31:0]  wr_data_i = '0;
  logic         wr_en_i = 1'b0;
  logic         wr_busy_o;
  logic [2:0]   req_tc_i = '0;
  logic         req_td_i = 1'b0;
  logic         req_ep_i = 1'b0;
  logic [1:0]   req_attr_i = '0;
  logic [9:0]   req_len_i = '0;
  logic [15:0]  req_rid_i = '0;
  logic [7:0]   req_tag_i = '0;
  logic [7:0]   req_be_i = '0;
  logic [12:0]  req_addr_i = '0;
  logic         us_cmd_fifo_full_i = 1'b0;
  logic         us_cmd_fifo_prog_full_i = 1'b0;
  logic [127:0] us_cmd_fifo_din_o;
  logic         us_cmd_fifo_wr_en_o;
  logic         irq_o;

  inbound_mc_ctrl #(.NUM_CH(N), .LEN_RST(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_wr_cmd_compl_i(up_wr_cmd_compl_i), .cmd_id_i(cmd_id_i),
    .req_compl_i(req_compl_i),
    .req_compl_with_data_i(req_compl_with_data_i),
    .to_rxe_compl_done_o(to_rxe_compl_done_o),
    .rd_addr_i(rd_addr_i), .rd_be_i(rd_be_i), .rd_data_o(rd_data_o),
    .wr_addr_i(wr_addr_i), .wr_be_i(wr_be_i), .wr_data_i(wr_data_i),
    .wr_en_i(wr_en_i), .wr_busy_o(wr_busy_o),
    .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i),
    .req_attr_i(req_attr_i), .req_len_i(req_len_i),
    .req_rid_i(req_rid_i), .req_tag_i(req_tag_i), .req_be_i(req_be_i),
    .req_addr_i(req_addr_i),
    .us_cmd_fifo_full_i(us_cmd_fifo_full_i),
    .us_cmd_fifo_prog_full_i(us_cmd_fifo_prog_full_i),
    .us_cmd_fifo_din_o(us_cmd_fifo_din_o),
    .us_cmd_fifo_wr_en_o(us_cmd_fifo_wr_en_o),
    .irq_o(irq_o)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[9];

  bit          m_pend[N], m_busy[N], m_done[N], m_ien[N];
  logic [31:0] m_addr[N];
  logic [4:0]  m_len;
  bit          m_cpl, m_cpld;
  logic [54:0] m_desc;
  int          m_next;

  function automatic logic [31:0] sw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [127:0] exp_wr(input int ch,
      input logic [4:0] l, input logic [31:0] a);
    logic [127:0] e = '0;
    e[31:0]  = a;
    e[56:55] = US_CMD_WR32_TYPE;
    e[61:57] = l;
    e[64:62] = 3'(ch);
    return e;
  endfunction

  function automatic logic [127:0] exp_cpl(input logic [1:0] t,
      input logic [4:0] l, input logic [54:0] d);
    logic [127:0] e = '0;
    e[54:0]  = d;
    e[56:55] = t;
    e[61:57] = l;
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    up_wr_cmd_compl_i = 1'b0;
    cmd_id_i = '0;
    req_compl_i = 1'b0;
    req_compl_with_data_i = 1'b0;
    wr_en_i = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    rd_addr_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    us_cmd_fifo_full_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_wr_en", 128'(us_cmd_fifo_wr_en_o), 128'(0));
    chk("rst_din", us_cmd_fifo_din_o, 128'(0));
    chk("rst_rxe", 128'(to_rxe_compl_done_o), 128'(0));
    chk("rst_wr_busy", 128'(wr_busy_o), 128'(0));
    chk("rst_irq", 128'(irq_o), 128'(0));
    chk("rst_pending", 128'(rd_data_o), 128'(0));
    rd_addr_i = 11'd1;
    #1;
    chk("rst_len", 128'(sw(rd_data_o)), 128'(6));
    rd_addr_i = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [4:0] idx, input logic [31:0] d);
    wr_addr_i = {6'd0, idx};
    wr_data_i = sw(d);
    wr_en_i = 1'b1;
    @(negedge clk);
    wr_en_i = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] idx, output logic [31:0] v);
    rd_addr_i = {6'd0, idx};
    #1;
    v = sw(rd_data_o);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_ien[i] = 0;
      m_addr[i] = '0;
    end
    m_len = 5'd6;
    m_cpl = 0;
    m_cpld = 0;
    m_desc = '0;
    m_next = 0;
  endtask

  task automatic model_step();
    bit          any_p, irq, bp[N], pp[N], cpl_pre;
    int          g, hit, ri, wi;
    logic [127:0] ed;
    logic [31:0] er, d;
    any_p = 0;
    irq = 0;
    for (int i = 0; i < N; i++) begin
      any_p |= m_pend[i];
      irq |= m_done[i] && m_ien[i];
      bp[i] = m_busy[i];
      pp[i] = m_pend[i];
    end
    g = -1;
    ed = '0;
    if (!us_cmd_fifo_full_i && m_cpl) begin
      ed = exp_cpl(m_cpld ? US_CMD_CPLD_TYPE : US_CMD_CPL_TYPE, m_len, m_desc);
    end else if (!us_cmd_fifo_full_i && any_p) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_next + k) % N]) g = (m_next + k) % N;
      ed = exp_wr(g, m_len, m_addr[g]);
    end
    ri = int'(rd_addr_i[4:0]);
    er = '0;
    if (ri == 1) er = 32'(m_len);
    else if (ri == 8 || ri == 9 || ri == 10 || ri == 11) er = m_addr[ri - 8];
    else if (ri == 0 || ri == 2 || ri == 3 || ri == 4)
      for (int i = 0; i < N; i++)
        er[i] = (ri == 0) ? m_pend[i] : (ri == 2) ? m_busy[i] :
                (ri == 3) ? m_done[i] : m_ien[i];
    chk("rnd_wr_en", 128'(us_cmd_fifo_wr_en_o),
        128'(!us_cmd_fifo_full_i && (m_cpl || any_p)));
    chk("rnd_din", us_cmd_fifo_din_o, ed);
    chk("rnd_rxe", 128'(to_rxe_compl_done_o),
        128'(!us_cmd_fifo_full_i && m_cpl));
    chk("rnd_wr_busy", 128'(wr_busy_o), 128'(m_cpl));
    chk("rnd_irq", 128'(irq_o), 128'(irq));
    chk("rnd_rd", 128'(sw(rd_data_o)), 128'(er));
    cpl_pre = m_cpl;
    if (!us_cmd_fifo_full_i && m_cpl) begin
      m_cpl = 0;
    end else if (g >= 0) begin
      m_pend[g] = 0;
      m_busy[g] = 1;
      m_next = (g + 1) % N;
    end
    hit = -1;
    if (up_wr_cmd_compl_i && int'(cmd_id_i) < N && bp[cmd_id_i]) hit = int'(cmd_id_i);
    if (hit >= 0) m_busy[hit] = 0;
    if (wr_en_i && !cpl_pre) begin
      wi = int'(wr_addr_i[4:0]);
      d = sw(wr_data_i);
      if (wi == 0) begin
        for (int i = 0; i < N; i++)
          if (d[i] && !bp[i] && !pp[i]) m_pend[i] = 1;
      end else if (wi == 1) m_len = d[4:0];
      else if (wi == 3) begin
        for (int i = 0; i < N; i++) if (d[i]) m_done[i] = 0;
      end else if (wi == 4) begin
        for (int i = 0; i < N; i++) m_ien[i] = d[i];
      end else if (wi >= 8 && wi < 8 + N) m_addr[wi - 8] = d;
    end
    if (hit >= 0) m_done[hit] = 1;
    if (!cpl_pre && req_compl_i) begin
      m_cpl = 1;
      m_cpld = req_compl_with_data_i;
      m_desc = {req_tc_i, req_td_i, req_ep_i, req_attr_i, req_len_i,
                req_rid_i, req_tag_i, req_be_i, req_addr_i[5:0]};
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [54:0] dsc;
    logic [4:0]  wsel[8];

    vt[0] = '{5'd1,  32'h0000_01F3, 32'h0000_0013};
    vt[1] = '{5'd4,  32'h0000_00FF, 32'h0000_000F};
    vt[2] = '{5'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[3] = '{5'd11, 32'h0BAD_F00D, 32'h0BAD_F00D};
    vt[4] = '{5'd2,  32'h0000_00FF, 32'h0000_0000};
    vt[5] = '{5'd5,  32'h0000_0055, 32'h0000_0000};
    vt[6] = '{5'd12, 32'h0000_0077, 32'h0000_0000};
    vt[7] = '{5'd3,  32'h0000_000F, 32'h0000_0000};
    vt[8] = '{5'd1,  32'h0000_0006, 32'h0000_0006};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      reg_write(vt[i].idx, vt[i].wdata);
      reg_read(vt[i].idx, v);
      chk($sformatf("tbl_reg%0d", vt[i].idx), 128'(v), 128'(vt[i].exp));
    end

    // Four channels issued back to back
    do_reset();
    for (int i = 0; i < 4; i++) reg_write(5'(8 + i), 32'hA000_0000 + i);
    reg_write(5'd0, 32'h0000_000F);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("seq4_wr_en%0d", i), 128'(us_cmd_fifo_wr_en_o), 128'(1));
      chk($sformatf("seq4_din%0d", i), us_cmd_fifo_din_o,
          exp_wr(i, 5'd6, 32'hA000_0000 + i));
      @(negedge clk);
    end
    #1;
    chk("seq4_idle", 128'(us_cmd_fifo_wr_en_o), 128'(0));
    reg_read(5'd2, v);
    chk("seq4_busy", 128'(v), 128'(32'hF));

    // Completion takes priority over pending channel work
    do_reset();
    us_cmd_fifo_full_i = 1'b1;
    reg_write(5'd0, 32'h3);
    req_tc_i = 3'd5; req_td_i = 1'b1; req_ep_i = 1'b0; req_attr_i = 2'd2;
    req_len_i = 10'h155; req_rid_i = 16'hBEEF; req_tag_i = 8'h5A;
    req_be_i = 8'hF0; req_addr_i = 13'h1ABC;
    dsc = {3'd5, 1'b1, 1'b0, 2'd2, 10'h155, 16'hBEEF, 8'h5A, 8'hF0, 6'h3C};
    req_compl_i = 1'b1;
    req_compl_with_data_i = 1'b1;
    @(negedge clk);
    clr_in();
    req_tc_i = '0; req_td_i = 1'b0; req_attr_i = '0; req_len_i = '0;
    req_rid_i = '0; req_tag_i = '0; req_be_i = '0; req_addr_i = '0;
    #1;
    chk("cpl_wr_busy", 128'(wr_busy_o), 128'(1));
    chk("cpl_stall", 128'(us_cmd_fifo_wr_en_o), 128'(0));
    us_cmd_fifo_full_i = 1'b0;
    #1;
    chk("cpl_rxe", 128'(to_rxe_compl_done_o), 128'(1));
    chk("cpl_din", us_cmd_fifo_din_o, exp_cpl(US_CMD_CPLD_TYPE, 5'd6, dsc));
    @(negedge clk);
    #1;
    chk("cpl_rxe_off", 128'(to_rxe_compl_done_o), 128'(0));
    chk("cpl_then_ch0", us_cmd_fifo_din_o, exp_wr(0, 5'd6, 32'h0));
    @(negedge clk);
    #1;
    chk("cpl_then_ch1", us_cmd_fifo_din_o, exp_wr(1, 5'd6, 32'h0));
    @(negedge clk);

    // FIFO full holds work without loss
    do_reset();
    reg_write(5'd8, 32'h1234_5678);
    us_cmd_fifo_full_i = 1'b1;
    reg_write(5'd0, 32'h1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("full_hold", 128'(us_cmd_fifo_wr_en_o), 128'(0));
      @(negedge clk);
    end
    us_cmd_fifo_full_i = 1'b0;
    #1;
    chk("full_release", us_cmd_fifo_din_o, exp_wr(0, 5'd6, 32'h1234_5678));
    @(negedge clk);

    // Completion, interrupt and DONE set-over-clear
    do_reset();
    reg_write(5'd4, 32'h4);
    reg_write(5'd0, 32'h4);
    #1;
    chk("irq_issue2", us_cmd_fifo_din_o, exp_wr(2, 5'd6, 32'h0));
    @(negedge clk);
    reg_read(5'd2, v);
    chk("irq_busy4", 128'(v), 128'(32'h4));
    up_wr_cmd_compl_i = 1'b1;
    cmd_id_i = 3'd2;
    @(negedge clk);
    clr_in();
    #1;
    chk("irq_on", 128'(irq_o), 128'(1));
    reg_read(5'd2, v);
    chk("irq_busy0", 128'(v), 128'(0));
    reg_read(5'd3, v);
    chk("irq_done4", 128'(v), 128'(32'h4));
    reg_write(5'd3, 32'h4);
    #1;
    chk("irq_off", 128'(irq_o), 128'(0));
    reg_write(5'd0, 32'h4);
    @(negedge clk);
    wr_addr_i = 11'd3;
    wr_data_i = sw(32'h4);
    wr_en_i = 1'b1;
    up_wr_cmd_compl_i = 1'b1;
    cmd_id_i = 3'd2;
    @(negedge clk);
    clr_in();
    reg_read(5'd3, v);
    chk("done_set_wins", 128'(v), 128'(32'h4));

    // Busy channel commands and out-of-range completions
    do_reset();
    reg_write(5'd0, 32'h1);
    @(negedge clk);
    reg_write(5'd0, 32'h1);
    #1;
    chk("busy_cmd_nowr", 128'(us_cmd_fifo_wr_en_o), 128'(0));
    reg_read(5'd0, v);
    chk("busy_cmd_pend", 128'(v), 128'(0));
    up_wr_cmd_compl_i = 1'b1;
    cmd_id_i = 3'd5;
    @(negedge clk);
    clr_in();
    reg_read(5'd2, v);
    chk("id5_busy", 128'(v), 128'(32'h1));
    reg_read(5'd3, v);
    chk("id5_done", 128'(v), 128'(0));
    up_wr_cmd_compl_i = 1'b1;
    cmd_id_i = 3'd0;
    wr_addr_i = 11'd0;
    wr_data_i = sw(32'h1);
    wr_en_i = 1'b1;
    @(negedge clk);
    clr_in();
    #1;
    chk("cmpl_cmd_nowr", 128'(us_cmd_fifo_wr_en_o), 128'(0));
    reg_read(5'd0, v);
    chk("cmpl_cmd_pend", 128'(v), 128'(0));
    reg_read(5'd3, v);
    chk("cmpl_cmd_done", 128'(v), 128'(32'h1));

    // Reset while work is pending discards it
    do_reset();
    us_cmd_fifo_full_i = 1'b1;
    reg_write(5'd0, 32'h3);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_wr_en", 128'(us_cmd_fifo_wr_en_o), 128'(0));
    chk("midrst_din", us_cmd_fifo_din_o, 128'(0));
    rd_addr_i = 11'd1;
    #1;
    chk("midrst_len", 128'(sw(rd_data_o)), 128'(6));
    rd_addr_i = '0;
    rst_n = 1'b1;
    us_cmd_fifo_full_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("midrst_noissue", 128'(us_cmd_fifo_wr_en_o), 128'(0));
      @(negedge clk);
    end

    // Randomized traffic against the model
    wsel = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd10, 5'd13};
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      us_cmd_fifo_full_i = ($urandom_range(0, 3) == 0);
      up_wr_cmd_compl_i = ($urandom_range(0, 2) == 0);
      cmd_id_i = 3'($urandom_range(0, 7));
      req_compl_i = ($urandom_range(0, 7) == 0);
      req_compl_with_data_i = 1'($urandom_range(0, 1));
      req_tc_i = 3'($urandom); req_td_i = 1'($urandom);
      req_ep_i = 1'($urandom); req_attr_i = 2'($urandom);
      req_len_i = 10'($urandom); req_rid_i = 16'($urandom);
      req_tag_i = 8'($urandom); req_be_i = 8'($urandom);
      req_addr_i = 13'($urandom);
      wr_en_i = ($urandom_range(0, 2) == 0);
      wr_addr_i = {6'($urandom), wsel[$urandom_range(0, 7)]};
      wr_data_i = $urandom;
      rd_addr_i = {6'($urandom), 5'($urandom_range(0, 15))};
      #1;
      model_step();
      @(negedge clk);
    end
    clr_in();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
